// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-stage hazard interface: ID/EX hazard sources in, pipeline stall/flush controls out.
interface pipe_hazard_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_use_rs;
  logic        id_use_rt;
  logic        id_md_start;
  logic        id_md_use;
  logic        ex_memread;
  logic [4:0]  ex_rd;
  logic        branch_taken;
  logic        pc_en;
  logic        ifid_en;
  logic        ifid_flush;
  logic        idex_bubble;
  logic        md_busy;
  logic [31:0] stall_cnt;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_md_start, id_md_use,
    output ex_memread, ex_rd, branch_taken,
    input  pc_en, ifid_en, ifid_flush, idex_bubble, md_busy, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_md_start, id_md_use,
    input  ex_memread, ex_rd, branch_taken,
    output pc_en, ifid_en, ifid_flush, idex_bubble, md_busy, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Load-use / mult-div hazard stall and taken-branch flush control for the PC and IF/ID register.
module pipe_hazard_ctrl #(
  parameter int unsigned MD_CYCLES = 32,
  parameter int unsigned CNT_W     = 6
) (
  input logic             Clk,
  input logic             Clr,
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic [0:0] {StRun, StMdBusy} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] md_cnt_q;
  logic [31:0]      stall_cnt_q;

  logic load_use;
  logic md_hold;
  logic stall;

  always_comb begin
    load_use = bus.ex_memread && (bus.ex_rd != 5'd0) &&
               ((bus.id_use_rs && (bus.id_rs == bus.ex_rd)) ||
                (bus.id_use_rt && (bus.id_rt == bus.ex_rd)));
    md_hold  = (state_q == StMdBusy) && (bus.id_md_use || bus.id_md_start);
    stall    = load_use || md_hold;
  end

  // Stall wins over flush: a branch seen while stalled is re-resolved next cycle.
  assign bus.pc_en       = ~stall;
  assign bus.ifid_en     = ~stall;
  assign bus.idex_bubble = stall;
  assign bus.ifid_flush  = bus.branch_taken & ~stall;
  assign bus.md_busy     = (state_q == StMdBusy);
  assign bus.stall_cnt   = stall_cnt_q;

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state_q     <= StRun;
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      unique case (state_q)
        StRun: begin
          if (bus.id_md_start && !stall) begin
            state_q  <= StMdBusy;
            md_cnt_q <= CNT_W'(MD_CYCLES - 1);
          end
        end
        StMdBusy: begin
          if (md_cnt_q == '0) begin
            state_q <= StRun;
          end else begin
            md_cnt_q <= md_cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboarded directed test of pipe_hazard_ctrl with MD_CYCLES=4.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic        pc_en;
    logic        ifid_en;
    logic        ifid_flush;
    logic        idex_bubble;
    logic        md_busy;
    logic [31:0] stall_cnt;
  } exp_t;

  logic clk;
  logic clr;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl #(
    .MD_CYCLES (4),
    .CNT_W     (3)
  ) dut (
    .Clk (clk),
    .Clr (clr),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input exp_t e, input string tag);
    chk({tag, ".pc_en"},       {31'd0, bus.pc_en},       {31'd0, e.pc_en});
    chk({tag, ".ifid_en"},     {31'd0, bus.ifid_en},     {31'd0, e.ifid_en});
    chk({tag, ".ifid_flush"},  {31'd0, bus.ifid_flush},  {31'd0, e.ifid_flush});
    chk({tag, ".idex_bubble"}, {31'd0, bus.idex_bubble}, {31'd0, e.idex_bubble});
    chk({tag, ".md_busy"},     {31'd0, bus.md_busy},     {31'd0, e.md_busy});
    chk({tag, ".stall_cnt"},   bus.stall_cnt,            e.stall_cnt);
  endtask

  // Drive one cycle of inputs just after the edge and queue the expected response.
  task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                      input logic urt, input logic mds, input logic mdu, input logic mr,
                      input logic [4:0] rd, input logic br, input logic stl, input logic fl,
                      input logic busy, input logic [31:0] cnt);
    exp_t e;
    @(posedge clk);
    #1;
    bus.id_rs        = rs;
    bus.id_rt        = rt;
    bus.id_use_rs    = urs;
    bus.id_use_rt    = urt;
    bus.id_md_start  = mds;
    bus.id_md_use    = mdu;
    bus.ex_memread   = mr;
    bus.ex_rd        = rd;
    bus.branch_taken = br;
    e.pc_en       = ~stl;
    e.ifid_en     = ~stl;
    e.ifid_flush  = fl;
    e.idex_bubble = stl;
    e.md_busy     = busy;
    e.stall_cnt   = cnt;
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic busy, input logic [31:0] cnt);
    step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, busy, cnt);
  endtask

  // Monitor: every falling edge with a queued expectation is compared.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk_all(e, "cyc");
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t r;
    checks = 0;
    errors = 0;
    clr = 1'b1;
    bus.id_rs = '0; bus.id_rt = '0; bus.id_use_rs = 0; bus.id_use_rt = 0;
    bus.id_md_start = 0; bus.id_md_use = 0; bus.ex_memread = 0; bus.ex_rd = '0;
    bus.branch_taken = 0;
    r = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0, idex_bubble: 1'b0,
          md_busy: 1'b0, stall_cnt: 32'd0};
    #2;
    chk_all(r, "reset");
    @(negedge clk);
    clr = 1'b0;

    //    rs     rt     urs urt mds mdu mr  rd     br  stl fl  busy cnt
    step(5'd0, 5'd0, 0,  0,  0,  0,  0,  5'd0, 0,  0,  0,  0,   32'd0); // idle
    step(5'd8, 5'd0, 1,  0,  0,  0,  1,  5'd8, 0,  1,  0,  0,   32'd0); // load-use rs
    idle(1'b0, 32'd1);
    step(5'd0, 5'd0, 1,  0,  0,  0,  1,  5'd0, 0,  0,  0,  0,   32'd1); // r0 never hazards
    step(5'd8, 5'd0, 0,  0,  0,  0,  1,  5'd8, 0,  0,  0,  0,   32'd1); // rs unused
    step(5'd1, 5'd9, 0,  1,  0,  0,  1,  5'd9, 0,  1,  0,  0,   32'd1); // load-use rt
    step(5'd3, 5'd4, 1,  1,  0,  0,  0,  5'd3, 1,  0,  1,  0,   32'd2); // branch flush
    step(5'd3, 5'd4, 1,  1,  0,  0,  1,  5'd3, 1,  1,  0,  0,   32'd2); // branch under stall
    idle(1'b0, 32'd3);

    // Mult/div: issue at cycle 0, busy 1..4, mflo held 2..4.
    step(5'd0, 5'd0, 0,  0,  1,  0,  0,  5'd0, 0,  0,  0,  0,   32'd3);
    idle(1'b1, 32'd3);
    step(5'd0, 5'd0, 0,  0,  0,  1,  0,  5'd0, 0,  1,  0,  1,   32'd3);
    step(5'd0, 5'd0, 0,  0,  0,  1,  0,  5'd0, 0,  1,  0,  1,   32'd4);
    step(5'd0, 5'd0, 0,  0,  0,  1,  0,  5'd0, 0,  1,  0,  1,   32'd5);
    step(5'd0, 5'd0, 0,  0,  0,  1,  0,  5'd0, 0,  0,  0,  0,   32'd6);

    // md_start blocked by a load-use must not issue.
    step(5'd7, 5'd0, 1,  0,  1,  0,  1,  5'd7, 0,  1,  0,  0,   32'd6);
    idle(1'b0, 32'd7);

    // Issue, then a second mult/div with a load-use while busy: one stall count.
    step(5'd0, 5'd0, 0,  0,  1,  0,  0,  5'd0, 0,  0,  0,  0,   32'd7);
    step(5'd5, 5'd0, 1,  0,  1,  0,  1,  5'd5, 0,  1,  0,  1,   32'd7);
    idle(1'b1, 32'd8);

    // Asynchronous clear while busy.
    @(posedge clk);
    #2;
    clr = 1'b1;
    #1;
    r.stall_cnt = 32'd0;
    chk_all(r, "clr_mid");
    @(negedge clk);
    clr = 1'b0;
    idle(1'b0, 32'd0);
    idle(1'b0, 32'd0);

    // Saturation: preload the counter near its ceiling, then keep stalling.
    @(posedge clk);
    #2;
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cnt_q;
    step(5'd8, 5'd0, 1,  0,  0,  0,  1,  5'd8, 0,  1,  0,  0,   32'hFFFF_FFFD);
    step(5'd8, 5'd0, 1,  0,  0,  0,  1,  5'd8, 0,  1,  0,  0,   32'hFFFF_FFFE);
    step(5'd8, 5'd0, 1,  0,  0,  0,  1,  5'd8, 0,  1,  0,  0,   32'hFFFF_FFFF);
    step(5'd8, 5'd0, 1,  0,  0,  0,  1,  5'd8, 0,  1,  0,  0,   32'hFFFF_FFFF);
    idle(1'b0, 32'hFFFF_FFFF);

    @(posedge clk);
    @(posedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
